z16_data_ram: RTL
=================

Z16_DATA_RAM -- requirements
Module: z16_data_ram

Interface
REQ-001 Parameter DATA_W, default 16, data word width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter DEPTH, default 1024, number of words; SHALL be a power of two and at least 2.
REQ-003 Parameter ADDR_W, default 16, byte-address width; SHALL be at least AB + IW, where AB = log2(DATA_W/8) and IW = log2(DEPTH).
REQ-004 Port i_clk, input, 1, clock; all state SHALL update on its rising edge.
REQ-005 Port i_rst, input, 1, reset; SHALL be asynchronous and active-high.
REQ-006 Port i_req, input, 1, access request; a request is accepted in a cycle where i_req=1 and o_ready=1.
REQ-007 Port i_wen, input, 1, 1=store, 0=load; sampled on acceptance.
REQ-008 Port i_addr, input, ADDR_W, byte address.
REQ-009 Port i_be, input, DATA_W/8, byte-lane write enables; bit k controls bits [8k+7:8k]; ignored for loads.
REQ-010 Port i_data, input, DATA_W, store data.
REQ-011 Port i_clr, input, 1, single-cycle request to zero the whole array.
REQ-012 Port o_ready, output, 1, block can accept a request this cycle.
REQ-013 Port o_ack, output, 1, one-cycle pulse one cycle after every accepted request.
REQ-014 Port o_data, output, DATA_W, load data; valid when o_ack=1 for a load.
REQ-015 Port o_err, output, 1, qualifies o_ack; 1 = the accepted access faulted.
REQ-016 Port o_busy, output, 1, clear sequence in progress.

Function
REQ-017 Word index SHALL be i_addr[AB+IW-1:AB].
REQ-018 Misaligned access (i_addr[AB-1:0] != 0 when AB>0) SHALL fault.
REQ-019 Out-of-range access (any i_addr bit at position >= AB+IW set) SHALL fault.
REQ-020 Faulted store SHALL NOT modify memory; a faulted access SHALL produce o_ack=1, o_err=1 and o_data=0 on the next cycle.
REQ-021 Accepted store SHALL update only the lanes with i_be=1 at the acceptance edge; other lanes SHALL be unchanged. i_be=0 SHALL be legal: it is a no-op with o_ack=1, o_err=0.
REQ-022 Accepted load SHALL register mem[index] so that o_data is valid with o_ack exactly one cycle after acceptance (read latency 1).
REQ-023 A load accepted in the cycle after a store to the same word SHALL return the post-store value.
REQ-024 o_data SHALL hold its last value when o_ack=0. o_err SHALL be 0 whenever o_ack=0. After a store ack, o_data SHALL be 0.
REQ-025 The FSM SHALL have two states, CLEAR and IDLE:
- CLEAR: o_busy=1, o_ready=0; writes 0 to word cnt each cycle, cnt increments from 0; at cnt=DEPTH-1 the FSM goes to IDLE.
- IDLE: o_busy=0, o_ready=1.
REQ-026 i_clr=1 in IDLE SHALL move the FSM to CLEAR with cnt=0 on the next edge, and any request in that same cycle SHALL still be accepted and served first.
REQ-027 i_clr during CLEAR SHALL be ignored. Requests during CLEAR SHALL NOT be accepted and SHALL produce no o_ack.
REQ-028 A full clear SHALL take exactly DEPTH cycles from entering CLEAR to o_ready=1.

Reset
REQ-029 Asserting i_rst SHALL immediately set state=CLEAR, cnt=0, o_ack=0, o_err=0, o_data=0, o_ready=0 and o_busy=1.
REQ-030 Array contents are undefined while i_rst is high. After i_rst deasserts, the clear SHALL run from word 0, and memory SHALL read all-zero once o_ready rises.
REQ-031 Reset asserted mid-clear or mid-access SHALL abort the operation and restart the clear; no o_ack SHALL be issued for the aborted request.

Verification (defaults DATA_W=16, DEPTH=1024)
REQ-032 Release reset, hold i_req=1 -> o_ready=0 for exactly 1024 cycles, no o_ack; then load addr 0x07FE -> o_data=0x0000, o_err=0.
REQ-033 Store 0xBEEF to 0x0010 with be=11, next cycle load 0x0010 -> ack with 0xBEEF one cycle after the load; then store 0x1234 with be=01 and load -> 0xBE34.
REQ-034 Load 0x0011 and store 0x0800 -> each gives o_ack=1, o_err=1, o_data=0; a later load of 0x0000 shows memory unchanged.
REQ-035 Pulse i_clr together with a store of 0xAAAA to 0x0020 -> store acked, o_busy=1 for 1024 cycles; after that, load 0x0020 -> 0x0000.
REQ-036 Assert i_rst at clear cycle 500 -> outputs reset immediately; after release, the clear lasts a full 1024 cycles.
REQ-037 Parameter sweep DATA_W=32, DEPTH=16 -> address 0x0002 faults misaligned, 0x0040 faults out-of-range, and a be=0100 store writes bits [23:16] only.

Source files
------------

// File: rtl/z16_data_ram.sv
// z16_data_ram: single-port byte-lane-writable data RAM with 1-cycle load
// latency, alignment/range fault detection and a hardware zero-fill sequence
// that runs out of reset and on request.
module z16_data_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req,
  input  logic                i_wen,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                i_clr,
  output logic                o_ready,
  output logic                o_ack,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_err,
  output logic                o_busy
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned AB = $clog2(NB);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << AB) - 1);
  localparam logic [IW-1:0]     LAST_IDX   = IW'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IW-1:0] idx;
  logic          misaligned;
  logic          out_of_range;
  logic          fault;
  logic          accept;

  // Address decode: word index plus the two fault conditions.
  always_comb begin
    idx          = i_addr[AB+IW-1:AB];
    misaligned   = |(i_addr & ALIGN_MASK);
    out_of_range = (i_addr >> (AB + IW)) != '0;
    fault        = misaligned | out_of_range;
    accept       = i_req & o_ready;
  end

  // State register: async reset forces a fresh clear from word 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: clear walks every word, i_clr is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (i_clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // FSM outputs: ready only in IDLE, busy only in CLEAR.
  always_comb begin
    o_ready = (state_q == ST_IDLE);
    o_busy  = (state_q == ST_CLEAR);
  end

  // Response next-state: faults and stores return zero, idle cycles hold data.
  always_comb begin
    ack_d   = accept;
    err_d   = accept & fault;
    rdata_d = rdata_q;
    if (accept) begin
      rdata_d = (fault || i_wen) ? '0 : mem[idx];
    end
  end

  // Response registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array write port: zero-fill during CLEAR, lane-masked stores in IDLE.
  always_ff @(posedge i_clk) begin
    if (state_q == ST_CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (accept && i_wen && !fault) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (i_be[k]) mem[idx][8*k +: 8] <= i_data[8*k +: 8];
      end
    end
  end

  assign o_ack  = ack_q;
  assign o_err  = err_q;
  assign o_data = rdata_q;

endmodule
